// File: rtl/token_pacer.sv
// token_pacer
//   Buffers a 1-bit-per-cycle token stream in a saturating pending counter
//   and re-emits the tokens on a valid/ready interface. After each accepted
//   output token it inserts GAP forced idle cycles. Tokens that arrive while
//   the counter is full are dropped, and a sticky overflow flag records the loss.
//
// Parameters
//   W       pending-count width; the counter saturates at 2**W-1
//   GAP     forced idle cycles after each handshake (0 allowed)
//   DROP_W  drop-counter width (only with TOKEN_PACER_DROP_CNT_EN)
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        asynchronous reset, active low
//   in_tok     incoming token (one per cycle when 1)
//   out_valid  token available downstream (registered)
//   out_ready  downstream accept; handshake = out_valid & out_ready
//   level      pending token count (registered)
//   empty      level == 0
//   overflow   sticky; a token was dropped while level was at maximum
//   drop_cnt   saturating count of dropped tokens
//              (present only with TOKEN_PACER_DROP_CNT_EN)
//
// Optional feature macro: TOKEN_PACER_DROP_CNT_EN
//   When defined, the drop_cnt port is added and overflow = (drop_cnt != 0).
//   When undefined, overflow is a single sticky flag.
module token_pacer #(
  parameter int unsigned W      = 4,
  parameter int unsigned GAP    = 2,
  parameter int unsigned DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_tok,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      level,
  output logic              empty,
  output logic              overflow
`ifdef TOKEN_PACER_DROP_CNT_EN
  ,
  output logic [DROP_W-1:0] drop_cnt
`endif
);

  localparam logic [W-1:0] MAX = '1;
  // The gap counter must hold the value GAP. Keep it at least 1 bit wide
  // so that GAP of 0 or 1 still gives a legal vector.
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_e;

  state_e         state_q;
  logic [GW-1:0]  gap_q;
  logic           out_valid_q;
  logic [W-1:0]   level_q;
  logic [W-1:0]   level_d;
  logic           hs;
  logic           drop;

  // Pending-count update. A token that arrives on the same edge as a
  // handshake replaces the departing one, so nothing is dropped even at MAX.
  always_comb begin
    hs      = out_valid_q & out_ready;
    drop    = 1'b0;
    level_d = level_q;
    if (in_tok && !hs) begin
      if (level_q == MAX) begin
        drop = 1'b1;
      end else begin
        level_d = level_q + W'(1);
      end
    end else if (!in_tok && hs) begin
      // out_valid implies level >= 1, so this cannot underflow
      level_d = level_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  // Output pacing FSM. out_valid is registered together with the state so
  // that it always equals (state == ST_SEND). Transitions use the
  // post-update count, which gives one cycle of latency from in_tok to
  // out_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      gap_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (level_d != '0) begin
            state_q     <= ST_SEND;
            out_valid_q <= 1'b1;
          end
        end
        ST_SEND: begin
          // Hold valid until the downstream consumer takes the token.
          if (hs) begin
            if (GAP > 0) begin
              state_q     <= ST_GAP;
              gap_q       <= GW'(GAP);
              out_valid_q <= 1'b0;
            end else if (level_d == '0) begin
              state_q     <= ST_IDLE;
              out_valid_q <= 1'b0;
            end
          end
        end
        ST_GAP: begin
          gap_q <= gap_q - GW'(1);
          // Leaving when the counter reads 1 gives exactly GAP idle cycles.
          if (gap_q == GW'(1)) begin
            if (level_d != '0) begin
              state_q     <= ST_SEND;
              out_valid_q <= 1'b1;
            end else begin
              state_q     <= ST_IDLE;
              out_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef TOKEN_PACER_DROP_CNT_EN
  logic [DROP_W-1:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_q <= drop_cnt_q + DROP_W'(1);
    end
  end

  assign drop_cnt = drop_cnt_q;
  // A nonzero drop count is the sticky loss indication.
  assign overflow = (drop_cnt_q != '0);
`else
  logic overflow_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;
`endif

  assign out_valid = out_valid_q;
  assign level     = level_q;
  assign empty     = (level_q == '0);

endmodule

// File: doc/token_pacer.md
Name: token_pacer

Overview:
- Downstream consumer of the token-doubling stage; takes its 1-bit-per-cycle token stream on `in_tok`.
- Buffers pending tokens in a saturating counter.
- Re-emits tokens on a valid/ready interface, one per handshake, with a programmable minimum idle gap between outputs.
- Flags lost tokens with a sticky overflow.

Parameters:
- W, 4: pending-count width; MAX = 2**W-1 (15 at default).
- GAP, 2: number of forced idle cycles (`out_valid`=0) after each accepted output token; 0 allowed.
- DROP_W, 8: width of drop counter (used only with the optional feature).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- in_tok  input  1  one token per cycle when 1.
- out_valid  output  1  token available downstream.
- out_ready  input  1  downstream accepts; handshake = out_valid & out_ready.
- level  output  W  pending token count (registered).
- empty  output  1  level == 0.
- overflow  output  1  sticky: a token was dropped because level was MAX.

Behaviour:
- Reset (rst=0, asynchronous, no clock edge needed):
  - level=0, empty=1, out_valid=0, overflow=0, state=IDLE, gap counter=0.
  - Reset mid-operation discards all pending tokens.
  - First token accepted on the first rising edge with rst=1.
- Count update per edge (hs = out_valid & out_ready):
  - in_tok & ~hs: level+1 if level<MAX; else level stays MAX, token dropped, overflow<=1.
  - ~in_tok & hs: level-1.
  - in_tok & hs: level unchanged; no overflow even at level==MAX.
  - Neither: unchanged.
  - Never wraps; underflow is impossible because out_valid implies level>=1.
- overflow: sticky; cleared only by reset.
- FSM states IDLE, SEND, GAP; out_valid = (state==SEND). Next state uses level_next (post-update value):
  - IDLE: level_next!=0 -> SEND. A token on in_tok at edge t gives out_valid=1 in the cycle after t (1-cycle latency).
  - SEND: hold (out_valid stays 1) until hs.
    - On hs with GAP>0: -> GAP, load gap counter with GAP.
    - On hs with GAP==0: -> SEND if level_next!=0, else IDLE.
  - GAP: decrement gap counter each cycle. When it reaches 1: -> SEND if level_next!=0, else IDLE. Exactly GAP cycles of out_valid=0.
- Tokens keep arriving and counting in every state.
- out_valid must not drop without a handshake.
- Steady-state throughput with out_ready=1: one token per GAP+1 cycles.

Optional Feature:
- Macro: TOKEN_PACER_DROP_CNT_EN.
- Defined:
  - Adds output port `drop_cnt` (DROP_W bits, reset 0), incremented on every dropped token.
  - Saturates at 2**DROP_W-1; no wrap.
  - overflow = (drop_cnt != 0).
- Undefined:
  - Port absent; overflow is the single sticky flag.
  - All other behaviour identical.

Test Plan:
- Async reset: with level=7 and out_valid=1, pull rst low between edges -> level=0, empty=1, out_valid=0, overflow=0 immediately, before the next clock edge.
- Single token, out_ready=1, GAP=2: in_tok=1 at edge 0 only -> out_valid=1 in cycle 1 only, handshake at edge 1, level=0, out_valid=0 thereafter.
- Burst pacing, GAP=2, out_ready=1: in_tok=1 for 5 consecutive edges -> out_valid high in cycles 1,4,7,10,13 only, exactly 5 handshakes, final level=0.
- Backpressure and overflow: out_ready=0, 16 consecutive tokens -> after 15 tokens level=15 and overflow=0; after the 16th, level=15, overflow=1 (drop_cnt=1 if macro defined); then out_ready=1 -> exactly 15 handshakes, level=0, overflow stays 1.
- Simultaneous event: level=15, out_valid=1, in_tok=1 and out_ready=1 on the same edge -> level stays 15, overflow stays 0.
- Doubler-style traffic, GAP=0: random in_tok at 30% density for 200 cycles with out_ready random 50%, then in_tok=0 and out_ready=1 for 300 cycles -> handshake count equals input token count, level=0, overflow=0 (W=4 must not saturate at 30% with 50% drain; use W=6 if it does).
